// File: rtl/pc_fetch_pkg.sv
// Shared fetch-unit definitions: FSM states, NOP word,
// next-PC operation codes and small helpers.
package pc_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_TRAP  = 3'd4
    } fetch_state_e;

    typedef enum logic [1:0] {
        NPC_PC4  = 2'd0,
        NPC_BR   = 2'd1,
        NPC_JAL  = 2'd2,
        NPC_JALR = 2'd3
    } npc_op_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic addr_aligned(input logic [31:0] a);
        return (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_reg.sv
// Program-counter register: 32-bit, async active-low reset,
// synchronous load enable.
module pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Hold unless a load is requested.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = d;
        end
    end

    // State register with async reset to the boot address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign q = pc_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: single-outstanding memory request,
// registered instruction word, sticky misalignment trap.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        pc_we,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        misalign
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  inst_q;
    logic [31:0]  inst_d;
    logic         misalign_q;
    logic         misalign_d;
    logic         pc_load;
    logic         accept;

    pc_reg #(
        .RESET_VAL(RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst_n(rst),
        .load (pc_load),
        .d    (npc),
        .q    (pc)
    );

    assign accept = pc_we && !stall;

    // Next-state, instruction latch and trap logic.
    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        misalign_d = misalign_q;
        pc_load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (accept) begin
                    pc_load = 1'b1;
                    if (addr_aligned(npc)) begin
                        state_d = S_REQ;
                    end else begin
                        state_d    = S_TRAP;
                        misalign_d = 1'b1;
                    end
                end
            end
            S_TRAP: begin
                misalign_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, instruction word and trap flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            inst_q     <= NOP_INST;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req   = (state_q == S_REQ);
    assign imem_addr  = pc;
    assign inst       = inst_q;
    assign inst_valid = (state_q == S_VALID);
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic        pc_we;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        misalign;

    int n_pass;
    int n_total;

    // Behavioural view: what the fetch unit is doing right now.
    bit          m_started;
    bit          m_need_req;
    bit          m_await_data;
    bit          m_have_inst;
    bit          m_trapped;
    logic [31:0] m_pc;
    logic [31:0] m_inst;

    pc_fetch #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .pc_we      (pc_we),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_need_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("inst", inst, m_inst);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_have_inst});
        chk("misalign", {31'd0, misalign}, {31'd0, m_trapped});
    endtask

    task automatic model_reset();
        m_started    = 0;
        m_need_req   = 0;
        m_await_data = 0;
        m_have_inst  = 0;
        m_trapped    = 0;
        m_pc         = 32'h0;
        m_inst       = 32'h0000_0013;
    endtask

    // Apply one edge of the specification's rules.
    task automatic model_edge();
        if (m_trapped) begin
        end else if (!m_started) begin
            m_started  = 1;
            m_need_req = 1;
        end else if (m_need_req) begin
            if (imem_gnt) begin
                m_need_req   = 0;
                m_await_data = 1;
            end
        end else if (m_await_data) begin
            if (imem_rvalid) begin
                m_inst       = imem_rdata;
                m_await_data = 0;
                m_have_inst  = 1;
            end
        end else if (m_have_inst && pc_we && !stall) begin
            m_pc        = npc;
            m_have_inst = 0;
            if (npc % 4 != 0) m_trapped = 1;
            else m_need_req = 1;
        end
    endtask

    task automatic cyc(input logic g, input logic rv,
                       input logic [31:0] rd, input logic we,
                       input logic st, input logic [31:0] n);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        pc_we       = we;
        stall       = st;
        npc         = n;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] word);
        cyc(1, 0, 32'h0, 0, 0, 32'h0);
        cyc(0, 1, word, 0, 0, 32'h0);
    endtask

    task automatic jump(input logic [31:0] target);
        cyc(0, 0, 32'h0, 1, 0, target);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst         = 1'b1;
        npc         = 32'h0;
        pc_we       = 1'b0;
        stall       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        model_reset();
        #2;
        do_reset();

        // Boot fetch: gnt next cycle, rvalid the one after.
        cyc(1, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        cyc(1, 0, 32'h0, 0, 0, 32'h0);
        cyc(0, 1, 32'h0050_0093, 0, 0, 32'h0);
        chk("boot_inst", inst, 32'h0050_0093);
        chk("boot_valid", {31'd0, inst_valid}, 32'd1);

        // Jump to 0x40 with grant held off three cycles.
        jump(32'h40);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 32'hBAD0_0000, 0, 0, 32'h0);
            chk("hold_addr", imem_addr, 32'h40);
        end
        cyc(1, 0, 32'h0, 0, 0, 32'h0);
        cyc(0, 1, 32'h0000_1111, 0, 0, 32'h0);
        chk("pc40", pc, 32'h40);

        // Stalled retire is ignored until stall drops.
        cyc(0, 0, 32'h0, 1, 1, 32'h80);
        cyc(0, 0, 32'h0, 1, 1, 32'h80);
        chk("stall_pc", pc, 32'h40);
        cyc(0, 0, 32'h0, 1, 0, 32'h80);
        chk("unstall_pc", pc, 32'h80);
        fetch(32'h0000_2222);

        // Wrap-around address then back to zero.
        jump(32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_3333);
        jump(32'h0);
        chk("zero_addr", imem_addr, 32'h0);
        chk("wrap_mis", {31'd0, misalign}, 32'd0);
        fetch(32'h0000_4444);

        // Reset while waiting for data; late rvalid ignored.
        jump(32'h10);
        cyc(1, 0, 32'h0, 0, 0, 32'h0);
        do_reset();
        cyc(0, 1, 32'h0BAD_0BAD, 0, 0, 32'h0);
        cyc(0, 1, 32'h0BAD_0BAD, 0, 0, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0000_0013);
        fetch(32'h0000_5555);

        // Misaligned target traps permanently.
        jump(32'h102);
        for (int i = 0; i < 10; i++) begin
            cyc(1'($urandom), 1'($urandom), $urandom,
                1'($urandom), 0, 32'h200);
            chk("trap_req", {31'd0, imem_req}, 32'd0);
        end
        chk("trap_pc", pc, 32'h102);
        chk("trap_mis", {31'd0, misalign}, 32'd1);
        do_reset();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] n;
            n = $urandom;
            if ($urandom_range(15) != 0) n[1:0] = 2'b00;
            cyc(1'($urandom), 1'($urandom), $urandom,
                1'($urandom), ($urandom_range(3) == 0), n);
            if (m_trapped && $urandom_range(7) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
